// File: rtl/door_pkg.sv
// door_pkg: shared state type, display codes and digit helpers for the door lock
package door_pkg;
  typedef enum logic [1:0] {LOCKED, OPEN, ALARM} state_t;
  localparam logic [7:0] SEG_L     = 8'h38;
  localparam logic [7:0] SEG_OPEN  = 8'h3F;
  localparam logic [7:0] SEG_ALARM = 8'hF7;
  function automatic logic is_bcd(input logic [3:0] n);
    return n <= 4'd9;
  endfunction
endpackage

// File: rtl/door_code_cmp.sv
// door_code_cmp: combinational check of four keyed digits against the stored password
module door_code_cmp
  import door_pkg::*;
#(
  parameter logic [15:0] PASSWORD = 16'h0247
) (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic [3:0] i_c,
  input  logic [3:0] i_d,
  output logic       o_match
);
  logic w_all_bcd;
  // a non-decimal digit never unlocks, even if its bits equal the password
  assign w_all_bcd = is_bcd(i_a) && is_bcd(i_b) && is_bcd(i_c) && is_bcd(i_d);
  assign o_match   = w_all_bcd && ({i_a, i_b, i_c, i_d} == PASSWORD);
endmodule

// File: rtl/door_lock.sv
// door_lock: combination lock FSM (LOCKED/OPEN/ALARM) with registered seven-segment status
module door_lock
  import door_pkg::*;
#(
  parameter logic [15:0] PASSWORD    = 16'h0247,
  parameter int          OPEN_CYCLES = 16,
  parameter int          MAX_FAIL    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enter,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] C,
  input  logic [3:0] D,
  output logic [7:0] S
);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int OW = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;
  localparam logic [OW-1:0] OPEN_LOAD = OW'(OPEN_CYCLES - 1);
  localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAIL - 1);
  localparam logic [FW-1:0] FAIL_SAT  = FW'(MAX_FAIL);
  state_t        r_state;
  logic [FW-1:0] r_fail;
  logic [OW-1:0] r_open;
  logic          w_match;
  door_code_cmp #(.PASSWORD(PASSWORD)) u_cmp (
    .i_a    (A),
    .i_b    (B),
    .i_c    (C),
    .i_d    (D),
    .o_match(w_match)
  );
  // state, counters and display code advance together so S always shows the post-edge state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LOCKED;
      r_fail  <= '0;
      r_open  <= '0;
      S       <= SEG_L;
    end else begin
      case (r_state)
        LOCKED: begin
          if (enter && w_match) begin
            r_state <= OPEN;
            r_open  <= OPEN_LOAD;
            r_fail  <= '0;
            S       <= SEG_OPEN;
          end else if (enter && r_fail == FAIL_LAST) begin
            r_state <= ALARM;
            r_fail  <= FAIL_SAT;
            S       <= SEG_ALARM;
          end else if (enter) begin
            r_fail  <= r_fail + FW'(1);
          end
        end
        OPEN: begin
          if (enter && w_match) begin
            r_open  <= OPEN_LOAD;
          end else if (r_open == '0) begin
            r_state <= LOCKED;
            S       <= SEG_L;
          end else begin
            r_open  <= r_open - OW'(1);
          end
        end
        default: begin
          r_state <= ALARM;
          S       <= SEG_ALARM;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_door_lock.sv
// tb_door_lock: randomized scoreboard bench for door_lock against a behavioural lock model
module tb_door_lock;
  localparam int OC = 16;
  localparam int MF = 3;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enter = 1'b0;
  logic [3:0] A = '0, B = '0, C = '0, D = '0;
  logic [7:0] s1, s2;
  always #5 clk = ~clk;
  door_lock u_dut1 (.clk(clk), .rst(rst), .enter(enter), .A(A), .B(B), .C(C), .D(D), .S(s1));
  door_lock #(.PASSWORD(16'hA247)) u_dut2 (.clk(clk), .rst(rst), .enter(enter), .A(A), .B(B), .C(C), .D(D), .S(s2));
  typedef struct {logic [7:0] e1; logic [7:0] e2;} exp_t;
  exp_t        q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] pw [2];
  int          fails [2];
  int          open_left [2];
  bit          alarm [2];
  function automatic logic [7:0] seg(input int k);
    return alarm[k] ? 8'hF7 : (open_left[k] > 0 ? 8'h3F : 8'h38);
  endfunction
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      fails[k] = 0;
      open_left[k] = 0;
      alarm[k] = 0;
    end
  endtask
  task automatic model_step(input bit en, input logic [15:0] code);
    for (int k = 0; k < 2; k++) begin
      bit m;
      m = (code == pw[k]);
      for (int i = 0; i < 4; i++) if (code[4*i +: 4] > 4'd9) m = 0;
      if (alarm[k]) begin
      end else if (open_left[k] > 0) begin
        if (en && m) open_left[k] = OC;
        else open_left[k]--;
      end else if (en) begin
        if (m) begin
          open_left[k] = OC;
          fails[k] = 0;
        end else begin
          fails[k]++;
          if (fails[k] >= MF) alarm[k] = 1;
        end
      end
    end
  endtask
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: S=%h expected %h", name, $time, act, exp);
    end
  endtask
  task automatic step(input bit en, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    @(negedge clk);
    enter = en;
    A = a; B = b; C = c; D = d;
    model_step(en, {a, b, c, d});
    q.push_back('{seg(0), seg(1)});
  endtask
  task automatic idle(input int n);
    repeat (n) step(0, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
  endtask
  task automatic do_reset();
    @(negedge clk);
    enter = 0;
    model_reset();
    q.push_back('{seg(0), seg(1)});
    #2 rst = 1;
    #1;
    check("async_rst_dut1", s1, 8'h38);
    check("async_rst_dut2", s2, 8'h38);
    @(negedge clk);
    rst = 0;
    model_step(0, 16'h0);
    q.push_back('{seg(0), seg(1)});
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("S_dut1", s1, e.e1);
      check("S_dut2", s2, e.e2);
    end
  end
  initial begin
    pw[0] = 16'h0247;
    pw[1] = 16'hA247;
    model_reset();
    do_reset();
    step(1, 0, 2, 4, 7);
    idle(18);
    repeat (3) step(1, 0, 2, 4, 6);
    step(1, 0, 2, 4, 7);
    idle(5);
    do_reset();
    repeat (2) step(1, 0, 2, 4, 6);
    step(1, 0, 2, 4, 7);
    idle(17);
    repeat (2) step(1, 0, 2, 4, 6);
    idle(2);
    do_reset();
    step(1, 4'hA, 2, 4, 7);
    idle(2);
    step(1, 0, 2, 4, 7);
    idle(15);
    step(1, 0, 2, 4, 7);
    idle(3);
    step(1, 9, 9, 9, 9);
    idle(15);
    step(1, 1, 1, 1, 1);
    step(1, 1, 1, 1, 1);
    idle(2);
    do_reset();
    repeat (600) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
      end else begin
        logic [15:0] code;
        int sel;
        sel = $urandom_range(0, 2);
        code = (sel == 0) ? 16'h0247 : (sel == 1) ? 16'hA247 : 16'($urandom);
        step($urandom_range(0, 3) == 0, code[15:12], code[11:8], code[7:4], code[3:0]);
      end
    end
    do_reset();
    @(posedge clk);
    #3;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
